// File: rtl/decode_pkg.sv
// Shared opcode constants, control-field encodings and the decoded control bundle
// passed from the combinational decoder to the decode-stage pipeline register.
package decode_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IALU   = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_SLT = 4'd2, ALU_SLTU = 4'd3, ALU_XOR = 4'd4,
    ALU_OR  = 4'd5, ALU_AND = 4'd6, ALU_SLL = 4'd7, ALU_SRL  = 4'd8, ALU_SRA = 4'd9
  } alu_op_e;

  typedef enum logic [3:0] {
    LSU_LB = 4'd0, LSU_LBU = 4'd1, LSU_LH = 4'd2, LSU_LHU = 4'd3, LSU_LW = 4'd4,
    LSU_SB = 4'd8, LSU_SH  = 4'd9, LSU_SW = 4'd10
  } lsu_op_e;

  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_LSU = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} wb_sel_e;

  // is_load travels with the bundle so the stage can spot load-use hazards
  typedef struct packed {
    logic       pc_sel;
    logic       rd_wren;
    logic       br_un;
    logic       opa_sel;
    logic       opb_sel;
    logic       mem_wren;
    logic       branch;
    logic       mdu_en;
    logic       illegal;
    alu_op_e    alu_op;
    lsu_op_e    lsu_op;
    wb_sel_e    wb_sel;
    logic [2:0] funct3;
    logic [2:0] mdu_op;
    logic [4:0] rd_addr;
    logic [4:0] rs1_addr;
    logic [4:0] rs2_addr;
    logic       is_load;
  } ctrl_t;

endpackage

// File: rtl/ctrl_decoder.sv
// Purely combinational RV32I(+M) instruction decoder producing the control bundle
// and the source-register usage flags needed by hazard detection.
module ctrl_decoder
  import decode_pkg::*;
#(
  parameter bit EN_MEXT = 1'b0
) (
  input  logic [31:0] instr,
  output ctrl_t       ctrl,
  output logic        rs1_used,
  output logic        rs2_used
);

  logic [4:0] opcode;
  logic [2:0] f3;
  logic       m_op;
  logic       bad;

  assign opcode = instr[6:2];
  assign f3     = instr[14:12];
  assign m_op   = (opcode == OP_R) && (instr[31:25] == 7'b0000001);

  assign rs1_used = !((opcode == OP_LUI) || (opcode == OP_AUIPC) || (opcode == OP_JAL));
  assign rs2_used = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);

  // alt selects SUB for funct3 000 and SRA for funct3 101
  function automatic alu_op_e alu_sel(input logic [2:0] f, input logic alt);
    case (f)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  always_comb begin
    ctrl          = '0;
    ctrl.opb_sel  = 1'b1;
    ctrl.alu_op   = ALU_ADD;
    ctrl.lsu_op   = LSU_LW;
    ctrl.wb_sel   = WB_ALU;
    ctrl.br_un    = instr[13];
    ctrl.funct3   = f3;
    ctrl.rd_addr  = instr[11:7];
    ctrl.rs1_addr = instr[19:15];
    ctrl.rs2_addr = instr[24:20];
    bad           = (instr[1:0] != 2'b11);
    case (opcode)
      OP_R: begin
        ctrl.opb_sel = 1'b0;
        ctrl.rd_wren = 1'b1;
        if (m_op) begin
          if (EN_MEXT) begin
            ctrl.mdu_en = 1'b1;
            ctrl.mdu_op = f3;
          end else begin
            bad = 1'b1;
          end
        end else begin
          ctrl.alu_op = alu_sel(f3, instr[30]);
        end
      end
      OP_IALU: begin
        ctrl.rd_wren = 1'b1;
        ctrl.alu_op  = alu_sel(f3, instr[30] && (f3 == 3'b101));
      end
      OP_LOAD: begin
        ctrl.rd_wren = 1'b1;
        ctrl.wb_sel  = WB_LSU;
        ctrl.is_load = 1'b1;
        case (f3)
          3'b000:  ctrl.lsu_op = LSU_LB;
          3'b001:  ctrl.lsu_op = LSU_LH;
          3'b010:  ctrl.lsu_op = LSU_LW;
          3'b100:  ctrl.lsu_op = LSU_LBU;
          3'b101:  ctrl.lsu_op = LSU_LHU;
          default: bad = 1'b1;
        endcase
      end
      OP_STORE: begin
        ctrl.mem_wren = 1'b1;
        case (f3)
          3'b000:  ctrl.lsu_op = LSU_SB;
          3'b001:  ctrl.lsu_op = LSU_SH;
          3'b010:  ctrl.lsu_op = LSU_SW;
          default: bad = 1'b1;
        endcase
      end
      OP_BRANCH: begin
        ctrl.opa_sel = 1'b1;
        ctrl.branch  = 1'b1;
        if ((f3 == 3'b010) || (f3 == 3'b011)) bad = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        ctrl.pc_sel  = 1'b1;
        ctrl.wb_sel  = WB_PC4;
        ctrl.rd_wren = 1'b1;
      end
      OP_LUI: begin
        ctrl.wb_sel  = WB_IMM;
        ctrl.rd_wren = 1'b1;
      end
      OP_AUIPC: begin
        ctrl.opa_sel = 1'b1;
        ctrl.rd_wren = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // an illegal instruction still flows down the pipe, but with no side effects
    if (bad) begin
      ctrl.illegal  = 1'b1;
      ctrl.rd_wren  = 1'b0;
      ctrl.mem_wren = 1'b0;
      ctrl.pc_sel   = 1'b0;
      ctrl.branch   = 1'b0;
      ctrl.mdu_en   = 1'b0;
      ctrl.is_load  = 1'b0;
    end
  end

endmodule

// File: rtl/ctrl_decode_stage.sv
// Decode pipeline stage: registers the decoded bundle, handles the IF/EX handshake
// and inserts a one-cycle bubble on load-use hazards, counting bubbles.
module ctrl_decode_stage
  import decode_pkg::*;
#(
  parameter bit EN_MEXT   = 1'b0,
  parameter bit EN_HAZARD = 1'b1,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_instr,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic             i_ready,
  input  logic             i_flush,
  output logic             o_valid,
  output logic             o_pc_sel,
  output logic             o_rd_wren,
  output logic             o_br_un,
  output logic             o_opa_sel,
  output logic             o_opb_sel,
  output logic             o_mem_wren,
  output logic             o_branch,
  output logic             o_mdu_en,
  output logic             o_illegal,
  output logic [3:0]       o_alu_op,
  output logic [3:0]       o_lsu_op,
  output logic [1:0]       o_wb_sel,
  output logic [2:0]       o_funct3,
  output logic [2:0]       o_mdu_op,
  output logic [4:0]       o_rd_addr,
  output logic [4:0]       o_rs1_addr,
  output logic [4:0]       o_rs2_addr,
  output logic [CNT_W-1:0] o_stall_cnt
);

  ctrl_t dec;
  ctrl_t q;
  logic  rs1_used;
  logic  rs2_used;
  logic  load_en;
  logic  hazard;
  logic  accept;

  ctrl_decoder #(.EN_MEXT(EN_MEXT)) u_decoder (
    .instr    (i_instr),
    .ctrl     (dec),
    .rs1_used (rs1_used),
    .rs2_used (rs2_used)
  );

  // Handshake: a transfer happens on a rising edge where valid && ready; the
  // producer holds valid/data until then, and a held output stays stable.
  assign load_en = !o_valid || i_ready;
  assign hazard  = EN_HAZARD && o_valid && q.is_load && (q.rd_addr != 5'd0) && i_valid &&
                   ((rs1_used && (dec.rs1_addr == q.rd_addr)) ||
                    (rs2_used && (dec.rs2_addr == q.rd_addr)));
  assign o_ready = load_en && !hazard && i_rst_n;
  assign accept  = i_valid && o_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid     <= 1'b0;
      q           <= '0;
      o_stall_cnt <= '0;
    end else if (i_flush) begin
      o_valid <= 1'b0;
    end else if (load_en) begin
      o_valid <= accept;
      if (accept) q <= dec;
      // hazard implies o_valid, so reaching here means EX took the load and a bubble follows
      if (hazard && (o_stall_cnt != {CNT_W{1'b1}})) o_stall_cnt <= o_stall_cnt + CNT_W'(1);
    end
  end

  assign o_pc_sel   = q.pc_sel;
  assign o_rd_wren  = q.rd_wren;
  assign o_br_un    = q.br_un;
  assign o_opa_sel  = q.opa_sel;
  assign o_opb_sel  = q.opb_sel;
  assign o_mem_wren = q.mem_wren;
  assign o_branch   = q.branch;
  assign o_mdu_en   = q.mdu_en;
  assign o_illegal  = q.illegal;
  assign o_alu_op   = q.alu_op;
  assign o_lsu_op   = q.lsu_op;
  assign o_wb_sel   = q.wb_sel;
  assign o_funct3   = q.funct3;
  assign o_mdu_op   = q.mdu_op;
  assign o_rd_addr  = q.rd_addr;
  assign o_rs1_addr = q.rs1_addr;
  assign o_rs2_addr = q.rs2_addr;

endmodule

// File: tb/tb_ctrl_decode_stage.sv
// Bench for ctrl_decode_stage: two instances (RV32I-only/16-bit counter and
// RV32M/2-bit counter) share stimulus and are checked against a reference model.
module tb_ctrl_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] i_instr;
  logic        i_valid, i_ready, i_flush;

  logic        a_ready, a_valid, a_pc_sel, a_rd_wren, a_br_un, a_opa_sel, a_opb_sel;
  logic        a_mem_wren, a_branch, a_mdu_en, a_illegal;
  logic [3:0]  a_alu_op, a_lsu_op;
  logic [1:0]  a_wb_sel;
  logic [2:0]  a_funct3, a_mdu_op;
  logic [4:0]  a_rd_addr, a_rs1_addr, a_rs2_addr;
  logic [15:0] a_stall_cnt;

  logic        b_ready, b_valid, b_pc_sel, b_rd_wren, b_br_un, b_opa_sel, b_opb_sel;
  logic        b_mem_wren, b_branch, b_mdu_en, b_illegal;
  logic [3:0]  b_alu_op, b_lsu_op;
  logic [1:0]  b_wb_sel;
  logic [2:0]  b_funct3, b_mdu_op;
  logic [4:0]  b_rd_addr, b_rs1_addr, b_rs2_addr;
  logic [1:0]  b_stall_cnt;

  logic [39:0] a_pack, b_pack;
  assign a_pack = {a_pc_sel, a_rd_wren, a_br_un, a_opa_sel, a_opb_sel, a_mem_wren, a_branch,
                   a_mdu_en, a_illegal, a_alu_op, a_lsu_op, a_wb_sel, a_funct3, a_mdu_op,
                   a_rd_addr, a_rs1_addr, a_rs2_addr};
  assign b_pack = {b_pc_sel, b_rd_wren, b_br_un, b_opa_sel, b_opb_sel, b_mem_wren, b_branch,
                   b_mdu_en, b_illegal, b_alu_op, b_lsu_op, b_wb_sel, b_funct3, b_mdu_op,
                   b_rd_addr, b_rs1_addr, b_rs2_addr};

  ctrl_decode_stage #(.EN_MEXT(1'b0), .EN_HAZARD(1'b1), .CNT_W(16)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_valid(i_valid), .o_ready(a_ready),
    .i_ready(i_ready), .i_flush(i_flush), .o_valid(a_valid), .o_pc_sel(a_pc_sel),
    .o_rd_wren(a_rd_wren), .o_br_un(a_br_un), .o_opa_sel(a_opa_sel), .o_opb_sel(a_opb_sel),
    .o_mem_wren(a_mem_wren), .o_branch(a_branch), .o_mdu_en(a_mdu_en), .o_illegal(a_illegal),
    .o_alu_op(a_alu_op), .o_lsu_op(a_lsu_op), .o_wb_sel(a_wb_sel), .o_funct3(a_funct3),
    .o_mdu_op(a_mdu_op), .o_rd_addr(a_rd_addr), .o_rs1_addr(a_rs1_addr),
    .o_rs2_addr(a_rs2_addr), .o_stall_cnt(a_stall_cnt)
  );

  ctrl_decode_stage #(.EN_MEXT(1'b1), .EN_HAZARD(1'b1), .CNT_W(2)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(i_instr), .i_valid(i_valid), .o_ready(b_ready),
    .i_ready(i_ready), .i_flush(i_flush), .o_valid(b_valid), .o_pc_sel(b_pc_sel),
    .o_rd_wren(b_rd_wren), .o_br_un(b_br_un), .o_opa_sel(b_opa_sel), .o_opb_sel(b_opb_sel),
    .o_mem_wren(b_mem_wren), .o_branch(b_branch), .o_mdu_en(b_mdu_en), .o_illegal(b_illegal),
    .o_alu_op(b_alu_op), .o_lsu_op(b_lsu_op), .o_wb_sel(b_wb_sel), .o_funct3(b_funct3),
    .o_mdu_op(b_mdu_op), .o_rd_addr(b_rd_addr), .o_rs1_addr(b_rs1_addr),
    .o_rs2_addr(b_rs2_addr), .o_stall_cnt(b_stall_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state: instruction currently held in the stage, bubble counters
  logic [31:0] exp_q[$];
  int          cnt_a, cnt_b;
  int          n_total, n_bad;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // reference decode straight from the instruction-set rules
  function automatic logic [39:0] ref_decode(input logic [31:0] ins, input bit mext);
    logic [4:0] op;
    logic [2:0] f3;
    int         alu, lsu, wb, mop;
    bit         pcs, wr, opa, opb, mw, br, md, ill;
    int         alu_tab[8] = '{0, 7, 2, 3, 4, 8, 5, 6};
    op  = ins[6:2];
    f3  = ins[14:12];
    alu = 0; lsu = 4; wb = 0; mop = 0;
    pcs = 0; wr = 0; opa = 0; opb = 1; mw = 0; br = 0; md = 0;
    ill = (ins[1:0] != 2'b11);
    case (op)
      5'b01100: begin
        opb = 0; wr = 1;
        if (ins[31:25] == 7'b0000001) begin
          if (mext) begin md = 1; mop = int'(f3); end
          else ill = 1;
        end else begin
          alu = alu_tab[f3];
          if (ins[30] && f3 == 3'd0) alu = 1;
          if (ins[30] && f3 == 3'd5) alu = 9;
        end
      end
      5'b00100: begin
        wr = 1; alu = alu_tab[f3];
        if (ins[30] && f3 == 3'd5) alu = 9;
      end
      5'b00000: begin
        wr = 1; wb = 1;
        case (f3)
          3'd0: lsu = 0;
          3'd1: lsu = 2;
          3'd2: lsu = 4;
          3'd4: lsu = 1;
          3'd5: lsu = 3;
          default: ill = 1;
        endcase
      end
      5'b01000: begin
        mw = 1;
        if (f3 > 3'd2) ill = 1;
        else lsu = 8 + int'(f3);
      end
      5'b11000: begin
        opa = 1; br = 1;
        if (f3 == 3'd2 || f3 == 3'd3) ill = 1;
      end
      5'b11011, 5'b11001: begin pcs = 1; wb = 2; wr = 1; end
      5'b01101: begin wb = 3; wr = 1; end
      5'b00101: begin opa = 1; wr = 1; end
      default: ill = 1;
    endcase
    if (ill) {pcs, wr, mw, br, md} = 5'b0;
    return {pcs, wr, ins[13], opa, opb, mw, br, md, ill, 4'(alu), 4'(lsu), 2'(wb), f3, 3'(mop),
            ins[11:7], ins[19:15], ins[24:20]};
  endfunction

  function automatic bit legal_load(input logic [31:0] ins);
    return (ins[6:0] == 7'b0000011) && (ins[14:12] inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
  endfunction

  function automatic bit reads_rs1(input logic [31:0] ins);
    return !(ins[6:2] inside {5'b01101, 5'b00101, 5'b11011});
  endfunction

  function automatic bit reads_rs2(input logic [31:0] ins);
    return ins[6:2] inside {5'b01100, 5'b01000, 5'b11000};
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  ops[9];
    logic [31:0] ins;
    ops = '{5'b01100, 5'b00100, 5'b00000, 5'b01000, 5'b11000, 5'b11011, 5'b11001, 5'b01101, 5'b00101};
    ins = $urandom();
    ins[6:2] = ($urandom_range(0, 9) == 0) ? 5'($urandom()) : ops[$urandom_range(0, 8)];
    // loads are the interesting producer, so make them common
    if ($urandom_range(0, 3) == 0) ins[6:2] = 5'b00000;
    if ($urandom_range(0, 15) != 0) ins[1:0] = 2'b11;
    ins[11:7]  = 5'($urandom_range(0, 3));
    ins[19:15] = 5'($urandom_range(0, 3));
    ins[24:20] = 5'($urandom_range(0, 3));
    case ($urandom_range(0, 3))
      0: ins[31:25] = 7'b0000000;
      1: ins[31:25] = 7'b0100000;
      2: ins[31:25] = 7'b0000001;
      default: ;
    endcase
    return ins;
  endfunction

  task automatic check_outputs();
    check("valid_a", a_valid, exp_q.size() != 0);
    check("valid_b", b_valid, exp_q.size() != 0);
    check("cnt_a", a_stall_cnt, cnt_a);
    check("cnt_b", b_stall_cnt, cnt_b);
    if (exp_q.size() != 0) begin
      check("bundle_a", a_pack, ref_decode(exp_q[0], 1'b0));
      check("bundle_b", b_pack, ref_decode(exp_q[0], 1'b1));
    end
  endtask

  task automatic check_reset_zero();
    check("rst_ready", {a_ready, b_ready}, 2'b00);
    check("rst_valid", {a_valid, b_valid}, 2'b00);
    check("rst_pack_a", a_pack, 40'd0);
    check("rst_pack_b", b_pack, 40'd0);
    check("rst_cnt", {a_stall_cnt, b_stall_cnt}, 18'd0);
  endtask

  // driver: one cycle of stimulus, then model update and output check
  task automatic step(input logic [31:0] ins, input bit v, input bit r, input bit f);
    bit haz, exp_rdy;
    @(negedge clk);
    i_instr = ins; i_valid = v; i_ready = r; i_flush = f;
    #1;
    haz = (exp_q.size() != 0) && legal_load(exp_q[0]) && (exp_q[0][11:7] != 5'd0) && v &&
          ((reads_rs1(ins) && ins[19:15] == exp_q[0][11:7]) ||
           (reads_rs2(ins) && ins[24:20] == exp_q[0][11:7]));
    exp_rdy = ((exp_q.size() == 0) || r) && !haz;
    check("ready_a", a_ready, exp_rdy);
    check("ready_b", b_ready, exp_rdy);
    if (f) begin
      exp_q.delete();
    end else if ((exp_q.size() == 0) || r) begin
      if (haz) begin
        if (cnt_a < 65535) cnt_a++;
        if (cnt_b < 3) cnt_b++;
      end
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      if (v && exp_rdy) exp_q.push_back(ins);
    end
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_zero();
    exp_q.delete();
    cnt_a = 0;
    cnt_b = 0;
    @(posedge clk);
    #1;
    check_reset_zero();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  localparam logic [31:0] ADD3  = 32'h002081B3;
  localparam logic [31:0] LW5   = 32'h0000A283;
  localparam logic [31:0] DEP5  = 32'h00028333;
  localparam logic [31:0] LW0   = 32'h0000A003;
  localparam logic [31:0] DEP0  = 32'h00000333;
  localparam logic [31:0] MUL3  = 32'h022081B3;
  localparam logic [31:0] BLTU  = 32'h0020E463;

  initial begin
    n_total = 0; n_bad = 0; cnt_a = 0; cnt_b = 0;
    rst_n = 1'b0; i_instr = '0; i_valid = 1'b0; i_ready = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_zero();
    @(negedge clk);
    rst_n = 1'b1;

    step(ADD3, 1, 1, 0);
    check("add_fields", {a_alu_op, a_opb_sel, a_rd_wren, a_rd_addr}, {4'd0, 1'b0, 1'b1, 5'd3});

    step(LW5, 1, 1, 0);
    step(DEP5, 1, 1, 0);
    check("bubble", {a_valid, a_stall_cnt}, {1'b0, 16'd1});
    step(DEP5, 1, 1, 0);
    step(LW0, 1, 1, 0);
    step(DEP0, 1, 1, 0);
    check("x0_no_bubble", {a_valid, a_stall_cnt}, {1'b1, 16'd1});

    step(MUL3, 1, 1, 0);
    check("mul_no_mext", {a_illegal, a_rd_wren, a_mdu_en}, 3'b100);
    check("mul_mext", {b_illegal, b_mdu_en, b_mdu_op, b_rd_wren}, {1'b0, 1'b1, 3'd0, 1'b1});

    step(BLTU, 1, 1, 0);
    check("bltu", {a_branch, a_br_un, a_funct3, a_opa_sel, a_rd_wren}, {1'b1, 1'b1, 3'b110, 1'b1, 1'b0});

    step(ADD3, 1, 1, 0);
    for (int k = 0; k < 3; k++) step(rand_instr(), 1, 0, 0);
    step(rand_instr(), 1, 0, 1);
    check("flush", a_valid, 1'b0);

    for (int k = 0; k < 5; k++) begin
      step(LW5, 1, 1, 0);
      step(DEP5, 1, 1, 0);
    end
    check("saturate", b_stall_cnt, 2'd3);

    step(LW5, 1, 1, 0);
    step(DEP5, 1, 0, 0);
    apply_reset();
    step(DEP5, 1, 1, 0);

    for (int k = 0; k < 600; k++)
      step(rand_instr(), $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 7,
           $urandom_range(0, 19) == 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/ctrl_decode_stage.md
CTRL_DECODE_STAGE -- requirements
Module: ctrl_decode_stage

Interface
REQ-001 SHALL have parameter: EN_MEXT, 0, 1 decodes RV32M ops and 0 flags them illegal.
REQ-002 SHALL have parameter: EN_HAZARD, 1, 1 enables load-use bubble insertion.
REQ-003 SHALL have parameter: CNT_W, 16, width of the stall-cycle counter.
REQ-004 SHALL have port: i_clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port: i_rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have ports: i_instr  in  32  fetched instruction; i_valid  in  1  instruction present; o_ready  out  1  stage accepts.
REQ-007 SHALL have ports: i_ready  in  1  EX accepts; i_flush  in  1  kill stage contents.
REQ-008 SHALL have port: o_valid  out  1  registered control bundle valid.
REQ-009 SHALL have ports, all registered: o_pc_sel, o_rd_wren, o_br_un, o_opa_sel, o_opb_sel, o_mem_wren, o_branch, o_mdu_en, o_illegal (1 each); o_alu_op 4; o_lsu_op 4; o_wb_sel 2; o_funct3 3; o_mdu_op 3; o_rd_addr, o_rs1_addr, o_rs2_addr 5 each.
REQ-010 SHALL have port: o_stall_cnt  out  CNT_W  saturating count of bubble cycles inserted.

Function
REQ-011 Encodings SHALL be: alu_op ADD0 SUB1 SLT2 SLTU3 XOR4 OR5 AND6 SLL7 SRL8 SRA9; lsu_op LB0 LBU1 LH2 LHU3 LW4 SB8 SH9 SW10; wb_sel ALU0 LSU1 PC+4 2 IMM3.
REQ-012 Decode per opcode[6:2] SHALL be: R 01100 (opb=rs2, rd_wren); I-ALU 00100; LOAD 00000 (wb LSU); STORE 01000 (mem_wren); BRANCH 11000 (opa=PC, branch=1); JAL 11011 and JALR 11001 (pc_sel=1, wb PC+4); LUI 01101 (wb IMM); AUIPC 00101 (opa=PC).
REQ-013 Defaults for unlisted fields SHALL be: opa=rs1, opb=imm, alu ADD, wb ALU, lsu LW, all enables 0.
REQ-014 SUB/SRA/SRAI SHALL be selected by instr[30]; o_br_un SHALL equal instr[13] (1 for BLTU/BGEU).
REQ-015 With EN_MEXT=1, opcode 01100 with funct7=0000001 SHALL give o_mdu_en=1, o_mdu_op=funct3, rd_wren=1, wb ALU.
REQ-016 Illegal cases SHALL be: instr[1:0]!=11, unknown opcode, branch funct3 010/011, load funct3 011/11x, store funct3 >010, M-op with EN_MEXT=0. Each SHALL register as valid with o_illegal=1 and rd_wren, mem_wren, pc_sel, branch, mdu_en all 0.
REQ-017 The pipeline register SHALL load when (!o_valid || i_ready); o_valid next SHALL equal i_valid && o_ready.
REQ-018 o_ready SHALL equal (!o_valid || i_ready) && !hazard && i_rst_n.
REQ-019 hazard SHALL equal EN_HAZARD && o_valid && registered instruction is LOAD && o_rd_addr!=0 && incoming i_valid && (rs1 used && rs1==o_rd_addr || rs2 used && rs2==o_rd_addr).
REQ-020 rs1 SHALL be used by all opcodes except LUI, AUIPC, JAL; rs2 SHALL be used by R, STORE, BRANCH only.
REQ-021 On hazard with i_ready=1, the stage SHALL register a bubble (o_valid=0) for exactly one cycle and o_stall_cnt SHALL increment, saturating at all-ones.
REQ-022 On hazard with i_ready=0, the stage SHALL hold its contents and SHALL NOT count.
REQ-023 While o_valid=1 and i_ready=0, all outputs SHALL hold stable.
REQ-024 i_flush SHALL dominate: next edge o_valid=0, incoming instruction dropped, o_stall_cnt unchanged.
REQ-025 Latency SHALL be one cycle from accept to o_valid.

Reset
REQ-026 While i_rst_n=0, all registered outputs SHALL be 0, including o_valid and o_stall_cnt, and o_ready SHALL be 0.
REQ-027 Reset asserted mid-stall SHALL discard the held instruction; the first post-reset accept SHALL behave as from empty.

Structure
REQ-028 Package decode_pkg SHALL hold the opcode constants and the alu_op_e, lsu_op_e and wb_sel_e enums.
REQ-029 Combinational decode SHALL live in sub-module ctrl_decoder; ctrl_decode_stage SHALL add only registers, handshake, hazard logic and counter.

Verification
REQ-030 0x002081B3 (ADD x3,x1,x2), i_ready=1 -> next cycle o_valid=1, alu_op=0, opb_sel=0, rd_wren=1, rd_addr=3.
REQ-031 0x0000A283 (LW x5) then 0x00028333 (ADD x6,x5,x0) -> one cycle o_valid=0 and o_ready=0, o_stall_cnt=1, then ADD valid; same with rd=x0 -> no bubble.
REQ-032 0x022081B3 -> EN_MEXT=0: o_illegal=1, rd_wren=0; EN_MEXT=1: mdu_en=1, mdu_op=0.
REQ-033 0x0020E463 (BLTU) -> branch=1, br_un=1, funct3=110, opa_sel=1, rd_wren=0.
REQ-034 i_ready=0 for 3 cycles with valid output -> outputs stable, o_ready=0; then i_flush=1 with i_valid=1 -> o_valid=0 next cycle.
REQ-035 Saturation (CNT_W=2, 5 hazards) -> o_stall_cnt=3; i_rst_n low mid-stall -> all outputs 0.
